// File: rtl/host_seq_pkg.sv
// host_seq_pkg: shared types and default constants for the host sequencer.
package host_seq_pkg;

   // Data memory and stream byte width.
   localparam int DW = 8;
   typedef logic [DW-1:0] byte_t;

   // Sequencer states; the encoding is visible on the internal 'state' signal.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   // Default configuration.
   localparam int          DEF_AW        = 8;
   localparam int          DEF_LOAD_BASE = 0;
   localparam int          DEF_RES_BASE  = 64;
   localparam int          DEF_RES_LEN   = 8;
   localparam int unsigned DEF_TIMEOUT   = 32'd4096;

endpackage

// File: rtl/hs_timeout_ctr.sv
// hs_timeout_ctr: 32-bit run-cycle counter with synchronous clear and enable.
// 'hit' is high during the enabled cycle in which the count equals LIMIT-1,
// i.e. the LIMIT-th enabled cycle since the last clear.
module hs_timeout_ctr
#(
   parameter int unsigned LIMIT = 32'd4096
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic hit
);

   logic [31:0] cnt;

   // Count enabled cycles; clear has priority over enable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 32'd1;
      end
   end

   assign hit = en && (cnt == (LIMIT - 32'd1));

endmodule

// File: rtl/host_seq.sv
// host_seq: host-side sequencer for the single-cycle core.
// Loads a byte image into data memory with the core held in reset, releases
// the core until it signals done (or a cycle timeout expires), then drains a
// fixed result window from data memory as a byte stream.
// Optional build macro HOST_SEQ_CKSUM_EN appends an XOR checksum beat to the
// result stream.
//
// Handshakes: a load byte transfers on a rising clk edge where ld_valid and
// ld_ready are both high; a result byte transfers on a rising clk edge where
// res_valid and res_ready are both high. While valid is high and ready low the
// presented byte and its last flag hold steady.
module host_seq
   import host_seq_pkg::*;
#(
   parameter int          AW        = DEF_AW,
   parameter int          LOAD_BASE = DEF_LOAD_BASE,
   parameter int          RES_BASE  = DEF_RES_BASE,
   parameter int          RES_LEN   = DEF_RES_LEN,
   parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [7:0]    ld_data,
   input  logic          ld_last,
   output logic          core_reset,
   input  logic          core_done,
   output logic          mem_wr_en,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wr_data,
   input  logic [7:0]    mem_rd_data,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [7:0]    res_data,
   output logic          res_last,
   output logic          busy,
   output logic          err_timeout
);

   // Base addresses reduced to the memory address width (wrap is intentional).
   localparam logic [AW-1:0] LB = AW'(LOAD_BASE);
   localparam logic [AW-1:0] RB = AW'(RES_BASE);
   // Result index is one bit wider so RES_LEN = 2^AW (and the checksum beat) fit.
   localparam logic [AW:0]   RL = (AW+1)'(RES_LEN);
`ifdef HOST_SEQ_CKSUM_EN
   localparam logic [AW:0]   LAST_IDX = RL;
`else
   localparam logic [AW:0]   LAST_IDX = RL - (AW+1)'(1);
`endif

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] ld_cnt;
   logic [AW:0]   rd_idx;
   logic          err_q;
   logic          ld_beat;
   logic          res_beat;
   logic          run_en;
   logic          run_clr;
   logic          run_hit;

   // RUN-cycle counter; held clear outside RUN so every run starts at zero.
   assign run_en  = (state == ST_RUN);
   assign run_clr = (state != ST_RUN);

   hs_timeout_ctr #(
      .LIMIT (TIMEOUT)
   ) u_timeout (
      .clk   (clk),
      .reset (reset),
      .clr   (run_clr),
      .en    (run_en),
      .hit   (run_hit)
   );

`ifdef HOST_SEQ_CKSUM_EN
   byte_t cksum;

   // XOR of accepted data beats; cleared whenever not draining.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cksum <= '0;
      end else if (state != ST_DRAIN) begin
         cksum <= '0;
      end else if (res_beat && (rd_idx < RL)) begin
         cksum <= cksum ^ mem_rd_data;
      end
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_nxt   = state;
      ld_ready    = 1'b0;
      core_reset  = 1'b1;
      mem_wr_en   = 1'b0;
      mem_addr    = LB + ld_cnt;
      mem_wr_data = '0;
      res_valid   = 1'b0;
      res_last    = 1'b0;
      res_data    = mem_rd_data;
      ld_beat     = 1'b0;
      res_beat    = 1'b0;
      case (state)
         ST_IDLE, ST_LOAD: begin
            // The state flop is already IDLE while reset is low; gate ready so
            // no write can happen until reset is released.
            ld_ready = reset;
            if (ld_valid && ld_ready) begin
               ld_beat     = 1'b1;
               mem_wr_en   = 1'b1;
               mem_wr_data = ld_data;
               state_nxt   = ld_last ? ST_RUN : ST_LOAD;
            end
         end
         ST_RUN: begin
            core_reset = 1'b0;
            if (core_done || run_hit) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            mem_addr  = RB + rd_idx[AW-1:0];
            res_valid = 1'b1;
            res_last  = (rd_idx == LAST_IDX);
`ifdef HOST_SEQ_CKSUM_EN
            if (rd_idx == RL) begin
               res_data = cksum;
            end
`endif
            if (res_ready) begin
               res_beat = 1'b1;
               if (res_last) begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Load/drain counters and the sticky timeout flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ld_cnt <= '0;
         rd_idx <= '0;
         err_q  <= 1'b0;
      end else begin
         if (ld_beat) begin
            ld_cnt <= ld_cnt + AW'(1);
         end
         if (ld_beat && (state == ST_IDLE)) begin
            err_q <= 1'b0;
         end
         // Done takes priority over a coincident timeout.
         if ((state == ST_RUN) && run_hit && !core_done) begin
            err_q <= 1'b1;
         end
         if (res_beat) begin
            if (res_last) begin
               rd_idx <= '0;
               ld_cnt <= '0;
            end else begin
               rd_idx <= rd_idx + (AW+1)'(1);
            end
         end
      end
   end

   assign busy        = (state != ST_IDLE);
   assign err_timeout = err_q;

endmodule

// File: tb/tb_host_seq.sv
// tb_host_seq: randomized scoreboard bench for host_seq with a memory model
// and a simple core model that writes its results then raises done.
module tb_host_seq;

  localparam int TB_LOAD_BASE = 0;
  localparam int TB_RES_BASE  = 64;
  localparam int TB_RES_LEN   = 8;
  localparam int TB_TIMEOUT   = 16;
`ifdef HOST_SEQ_CKSUM_EN
  localparam int TB_BEATS = TB_RES_LEN + 1;
`else
  localparam int TB_BEATS = TB_RES_LEN;
`endif

  logic       clk;
  logic       reset;
  logic       ld_valid;
  logic       ld_ready;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       core_reset;
  logic       core_done;
  logic       mem_wr_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_wr_data;
  logic [7:0] mem_rd_data;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_last;
  logic       busy;
  logic       err_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;

  logic [8:0] exp_q[$];
  logic [7:0] ld_bytes[$];
  logic [7:0] mem[256];
  logic [7:0] core_res[TB_RES_LEN];
  int         cfg_dly = 10;
  int         bp_mode = 0;
  int         rc = 0;
  int         last_run_cycles = 0;
  logic       core_done_m = 1'b0;
  logic       force_done = 1'b0;
  logic       core_we = 1'b0;
  logic [7:0] core_wa = '0;
  logic [7:0] core_wd = '0;
  logic       exp_err_prev = 1'b0;

  host_seq #(
    .AW        (8),
    .LOAD_BASE (TB_LOAD_BASE),
    .RES_BASE  (TB_RES_BASE),
    .RES_LEN   (TB_RES_LEN),
    .TIMEOUT   (TB_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .core_reset  (core_reset),
    .core_done   (core_done),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_last    (res_last),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // memory model: combinational read, two write ports (host and core)
  assign mem_rd_data = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    if (core_we) mem[core_wa] <= core_wd;
  end

  // core model: while released, write results in the first RES_LEN cycles,
  // raise done from cycle cfg_dly onward
  assign core_done = core_done_m | force_done;
  always @(negedge clk) begin
    core_we = 1'b0;
    if (!reset || core_reset) begin
      if (rc > 0) last_run_cycles = rc;
      rc = 0;
      core_done_m = 1'b0;
    end else begin
      if (rc < TB_RES_LEN) begin
        core_we = 1'b1;
        core_wa = 8'(TB_RES_BASE + rc);
        core_wd = core_res[rc];
      end
      if (rc >= cfg_dly) core_done_m = 1'b1;
      rc++;
    end
  end

  // downstream ready pattern
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = ~res_ready;
        default: res_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (reset && !core_reset) begin
      chk("run_no_wr", mem_wr_en, 0);
      chk("run_no_ld_ready", ld_ready, 0);
    end
    if (reset && res_valid) begin
      chk("drain_no_wr", mem_wr_en, 0);
      chk("drain_core_reset", core_reset, 1);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL res_extra: got beat %0h expected none", res_data);
      end else begin
        chk("res_data", res_data, exp_q[0][7:0]);
        chk("res_last", res_last, exp_q[0][8]);
        if (res_ready) begin
          void'(exp_q.pop_front());
          n_acc++;
        end
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_core_reset", core_reset, 1);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_last", res_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, TB_LOAD_BASE);
    chk("rst_wr_data", mem_wr_data, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_res_pass", res_data, mem[8'(TB_LOAD_BASE)]);
  endtask

  // driver: stream ld_bytes; called at posedge+1
  task automatic send_load(input int gap_pct);
    logic [7:0] a;
    int n;
    a = 8'(TB_LOAD_BASE);
    n = ld_bytes.size();
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        ld_valid = 1'b0;
        @(negedge clk);
        chk("stall_no_wr", mem_wr_en, 0);
        @(posedge clk);
        #1;
      end
      ld_valid = 1'b1;
      ld_data  = ld_bytes[i];
      ld_last  = (i == n - 1);
      @(negedge clk);
      chk("ld_ready", ld_ready, 1);
      chk("wr_en", mem_wr_en, 1);
      chk("wr_addr", mem_addr, a);
      chk("wr_data", mem_wr_data, ld_bytes[i]);
      if (i == 0) chk("err_before_beat", err_timeout, exp_err_prev);
      @(posedge clk);
      #1;
      if (i == 0) chk("err_cleared", err_timeout, 0);
      a = a + 8'd1;
      ld_valid = 1'b0;
      ld_last  = 1'b0;
    end
    force_done = 1'b0;
  endtask

  task automatic do_run(input int dly, input int bp, input int gap, input logic fdone, input logic do_rst);
    logic [7:0] ck;
    logic       lst;
    logic       exp_err;
    int         exp_cyc;
    int         cyc;
    int         acc0;
    cfg_dly = dly;
    bp_mode = bp;
    ck = '0;
    for (int i = 0; i < TB_RES_LEN; i++) begin
`ifdef HOST_SEQ_CKSUM_EN
      lst = 1'b0;
`else
      lst = (i == TB_RES_LEN - 1);
`endif
      exp_q.push_back({lst, core_res[i]});
      ck = ck ^ core_res[i];
    end
`ifdef HOST_SEQ_CKSUM_EN
    exp_q.push_back({1'b1, ck});
`endif
    exp_cyc = (dly + 1 < TB_TIMEOUT) ? dly + 1 : TB_TIMEOUT;
    exp_err = (dly > TB_TIMEOUT - 1);
    acc0 = n_acc;
    force_done = fdone;
    send_load(gap);
    @(negedge clk);
    chk("run_core_reset", core_reset, 0);
    chk("run_busy", busy, 1);
    if (do_rst) begin
      cyc = 0;
      while (n_acc < acc0 + 3 && cyc < 3000) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      chk("rst_three_beats", n_acc - acc0, 3);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      exp_q.delete();
      check_reset_outputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      exp_err_prev = 1'b0;
    end else begin
      cyc = 0;
      while (busy && cyc < 3000) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      chk("done_in_time", busy, 0);
      chk("drain_beats", n_acc - acc0, TB_BEATS);
      chk("queue_empty", exp_q.size(), 0);
      chk("run_cycles", last_run_cycles, exp_cyc);
      chk("err_timeout", err_timeout, exp_err);
      chk("idle_core_reset", core_reset, 1);
      exp_q.delete();
      exp_err_prev = exp_err;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_res();
    for (int i = 0; i < TB_RES_LEN; i++) core_res[i] = 8'($urandom);
  endtask

  task automatic rand_bytes(input int n);
    ld_bytes.delete();
    for (int i = 0; i < n; i++) ld_bytes.push_back(8'($urandom));
  endtask

  initial begin
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    reset    = 1'b0;
    #12;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // basic load 0x11,0x22,0x33; done 10 cycles into RUN; results A0..A7
    ld_bytes = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < TB_RES_LEN; i++) core_res[i] = 8'hA0 + 8'(i);
    do_run(10, 0, 0, 1'b0, 1'b0);

    // backpressure toggling every cycle
    rand_res();
    rand_bytes(5);
    do_run(12, 1, 30, 1'b0, 1'b0);

    // timeout, then sticky flag cleared by next first beat
    rand_res();
    rand_bytes(2);
    do_run(40, 0, 0, 1'b0, 1'b0);
    rand_res();
    rand_bytes(3);
    do_run(TB_TIMEOUT - 1, 2, 0, 1'b0, 1'b0);
    rand_res();
    rand_bytes(1);
    do_run(TB_TIMEOUT, 0, 0, 1'b0, 1'b0);

    // done asserted while core held in reset is ignored
    rand_res();
    rand_bytes(4);
    do_run(9, 0, 20, 1'b1, 1'b0);

    // reset mid-drain, then a fresh load from LOAD_BASE
    rand_res();
    rand_bytes(3);
    do_run(8, 0, 0, 1'b0, 1'b1);
    rand_res();
    rand_bytes(2);
    do_run(11, 2, 0, 1'b0, 1'b0);

    // load address wraps past the top of memory
    rand_res();
    rand_bytes(260);
    do_run(10, 0, 5, 1'b0, 1'b0);

    // checksum pattern
    core_res = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
    rand_bytes(2);
    do_run(8, 0, 0, 1'b0, 1'b0);

    // randomized runs
    for (int r = 0; r < 12; r++) begin
      rand_res();
      rand_bytes($urandom_range(1, 12));
      do_run($urandom_range(8, 22), $urandom_range(0, 2), $urandom_range(0, 40),
             ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/host_seq.md
Name: host_seq

Overview:
- Host-side sequencer for the single-cycle core: the other end of the core's start/`done` handshake and of its data memory.
- Streams a byte image into data memory through a write port while the core is held in reset.
- Releases the core and waits for `done` (with a cycle timeout).
- Drains a fixed result window from data memory as a valid/ready byte stream.
- Sits between the testbench/host link and the core's `clk`/`reset`/`done` pins plus a second port on `dat_mem`.

Parameters:
- AW, 8: data memory address width.
- LOAD_BASE, 0: first address written by the load stream.
- RES_BASE, 64: first address of the result window.
- RES_LEN, 8: result bytes drained; legal range 1..2^AW.
- TIMEOUT, 4096: maximum RUN cycles before abort; 32-bit count.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ld_valid  in  1  load byte valid
- ld_ready  out  1  sequencer accepts load byte
- ld_data  in  8  load byte
- ld_last  in  1  final load byte; starts run
- core_reset  out  1  active-high reset to core (matches core's reset pin)
- core_done  in  1  core `done`
- mem_wr_en  out  1  data memory write strobe
- mem_addr  out  AW  data memory address
- mem_wr_data  out  8  data memory write data
- mem_rd_data  in  8  data memory read data (combinational read)
- res_valid  out  1  result byte valid
- res_ready  in  1  downstream accepts result byte
- res_data  out  8  result byte
- res_last  out  1  final result byte
- busy  out  1  state != IDLE
- err_timeout  out  1  sticky: last run hit TIMEOUT

Behaviour:
- States: IDLE, LOAD, RUN, DRAIN.
- Reset (reset=0, async):
  - state=IDLE; all counters 0; err_timeout=0.
  - Outputs: core_reset=1, ld_ready=0, mem_wr_en=0, res_valid=0, res_last=0, busy=0, mem_addr=LOAD_BASE, mem_wr_data=0, res_data=mem_rd_data (pass-through).
- IDLE:
  - ld_ready=1, core_reset=1.
  - A beat (ld_valid&ld_ready) writes the same cycle: mem_wr_en=1, mem_addr=LOAD_BASE+ld_cnt (mod 2^AW), mem_wr_data=ld_data.
  - ld_cnt increments; go to LOAD.
  - If that beat also has ld_last, go directly to RUN.
  - err_timeout clears on the first accepted beat.
- LOAD:
  - Same write rule per beat; ld_ready=1.
  - Address wraps modulo 2^AW with no error.
  - Beat with ld_last -> RUN next cycle. ld_valid=0 cycles stall with no write.
- RUN:
  - core_reset=0, ld_ready=0; run_cnt increments each cycle.
  - core_done=1 is sampled registered -> DRAIN next cycle. core_done during core_reset=1 is ignored.
  - run_cnt==TIMEOUT-1 without done -> set err_timeout, DRAIN.
  - If done and timeout coincide, done wins and err_timeout stays 0.
- DRAIN:
  - core_reset=1 (core frozen); mem_addr=RES_BASE+rd_idx (mod 2^AW); res_data=mem_rd_data; res_valid=1; res_last=(rd_idx==RES_LEN-1).
  - rd_idx increments only on res_valid&res_ready. res_data holds steady while stalled.
  - The last accepted beat -> IDLE, with counters cleared.
- mem_wr_en is asserted only in IDLE/LOAD on an accepted beat; it is never asserted in RUN or DRAIN.
- Reset mid-operation: immediate return to IDLE. Partially loaded memory is not cleared.
- Zero-byte load is impossible: a run needs at least one beat, and ld_last marks it.

Optional Feature:
- HOST_SEQ_CKSUM_EN defined:
  - DRAIN emits RES_LEN+1 beats.
  - The extra final beat is the XOR of all RES_LEN result bytes.
  - res_last is on the checksum beat only.
  - The checksum register clears on entry to DRAIN and accumulates on each accepted data beat.
- Undefined: exactly RES_LEN beats; no checksum logic.

Decomposition:
- Package host_seq_pkg holds:
  - state enum (IDLE, LOAD, RUN, DRAIN) as 2-bit logic;
  - default constants for LOAD_BASE, RES_BASE, RES_LEN, TIMEOUT;
  - the DW=8 byte type.
- One sub-module, hs_timeout_ctr:
  - 32-bit counter with clear, enable, and `hit` output.
  - Used in RUN.
- Everything else is in the single FSM module.

Test Plan:
- Basic load: 3 beats 0x11,0x22,0x33 with last on the third -> writes addr 0,1,2 same cycles; state RUN; core_reset falls the next cycle.
- Done handshake: core_done asserted 10 cycles into RUN, memory at 64..71 = 0xA0..0xA7 -> 8 beats 0xA0..0xA7, res_last on 0xA7, then busy=0, core_reset=1.
- Backpressure: res_ready toggled 1/0 every cycle -> each byte held stable while stalled; no byte dropped or duplicated; 8 accepted beats total.
- Timeout: TIMEOUT=16, core_done held 0 -> DRAIN after 16 RUN cycles; err_timeout=1 until the next load beat.
- Async reset mid-DRAIN: after 3 beats, reset low for 2 cycles -> outputs immediately at reset values; a new load starts again at addr LOAD_BASE.
- HOST_SEQ_CKSUM_EN: results 0x01,0x02,0x04,0x08,0,0,0,0 -> 9 beats; final beat 0x0F with res_last.
